// File: rtl/mac_tx_arbiter.sv
// mac_tx_arbiter: packet-level round-robin arbiter in front of the MAC tx path.
// NUM_SRC frame sources share one 8-bit stream. One source is granted per frame
// and keeps the grant until its last beat is accepted, so frames never interleave.
// Optional feature macro: MAC_TX_ARB_GAP_EN inserts GAP_CYCLES idle cycles after
// every frame. Without it the GAP state and its counter do not exist.
module mac_tx_arbiter #(
    parameter int NUM_SRC    = 3,
    parameter int CNT_WIDTH  = 16,
    parameter int GAP_CYCLES = 12
) (
    input  logic                   logic_clk,
    input  logic                   logic_rst_n,
    input  logic [NUM_SRC*8-1:0]   src_data_in,
    input  logic [NUM_SRC-1:0]     src_valid_in,
    output logic [NUM_SRC-1:0]     src_ready_out,
    input  logic [NUM_SRC-1:0]     src_last_in,
    output logic [7:0]             mac_rnet_data_out,
    output logic                   mac_rnet_valid_out,
    input  logic                   mac_rnet_ready_in,
    output logic                   mac_rnet_last_out,
    output logic [NUM_SRC-1:0]     arb_grant_out,
    output logic                   arb_busy_out,
    output logic [CNT_WIDTH-1:0]   arb_frame_cnt_out
);

    localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_XFER = 2'b01,
        ST_GAP  = 2'b10
    } state_t;

    state_t               state_r;
    state_t               state_nxt_s;
    logic [NUM_SRC-1:0]   grant_r;
    logic [NUM_SRC-1:0]   sel_s;
    logic [PTR_W-1:0]     rr_ptr_r;
    logic [PTR_W-1:0]     cand_s;
    logic                 found_s;
    logic [PTR_W-1:0]     grant_idx_s;
    logic [PTR_W-1:0]     next_ptr_s;
    logic [CNT_WIDTH-1:0] frame_cnt_r;
    logic                 any_req_s;
    logic                 last_xfer_s;
    logic [7:0]           mux_data_s;
    logic                 mux_valid_s;
    logic                 mux_last_s;

`ifdef MAC_TX_ARB_GAP_EN
    localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES - 1);
    logic [7:0] gap_cnt_r;
`endif

    assign any_req_s = |src_valid_in;

    // Round-robin pick: first requester at or above rr_ptr_r, searching cyclically
    always_comb begin
        sel_s   = {NUM_SRC{1'b0}};
        found_s = 1'b0;
        cand_s  = {PTR_W{1'b0}};
        for (int i = 0; i < NUM_SRC; i++) begin
            cand_s = PTR_W'((int'(rr_ptr_r) + i) % NUM_SRC);
            if (!found_s && src_valid_in[cand_s]) begin
                sel_s[cand_s] = 1'b1;
                found_s       = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Encode the one-hot grant into an index and derive the next round-robin start
    always_comb begin
        grant_idx_s = {PTR_W{1'b0}};
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_r[i]) begin
                grant_idx_s = PTR_W'(i);
            end else begin
                grant_idx_s = grant_idx_s;
            end
        end
        if (grant_idx_s == PTR_W'(NUM_SRC - 1)) begin
            next_ptr_s = {PTR_W{1'b0}};
        end else begin
            next_ptr_s = grant_idx_s + PTR_W'(1'b1);
        end
    end

    // Zero-latency passthrough of the granted source; grant is zero outside XFER
    always_comb begin
        mux_data_s  = 8'h00;
        mux_valid_s = 1'b0;
        mux_last_s  = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_r[i]) begin
                mux_data_s  = mux_data_s | src_data_in[8*i +: 8];
                mux_valid_s = mux_valid_s | src_valid_in[i];
                mux_last_s  = mux_last_s | src_last_in[i];
            end else begin
                mux_data_s  = mux_data_s;
                mux_valid_s = mux_valid_s;
                mux_last_s  = mux_last_s;
            end
        end
    end

    assign last_xfer_s = (state_r == ST_XFER) & mux_valid_s & mac_rnet_ready_in & mux_last_s;

    // FSM state register
    always_ff @(posedge logic_clk or negedge logic_rst_n) begin
        if (!logic_rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    state_nxt_s = ST_XFER;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_XFER: begin
                if (last_xfer_s) begin
`ifdef MAC_TX_ARB_GAP_EN
                    state_nxt_s = ST_GAP;
`else
                    state_nxt_s = ST_IDLE;
`endif
                end else begin
                    state_nxt_s = ST_XFER;
                end
            end
            ST_GAP: begin
`ifdef MAC_TX_ARB_GAP_EN
                if (gap_cnt_r == 8'd0) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_GAP;
                end
`else
                state_nxt_s = ST_IDLE;
`endif
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: stream passthrough, per-source ready and busy flag
    always_comb begin
        mac_rnet_data_out  = mux_data_s;
        mac_rnet_valid_out = mux_valid_s;
        mac_rnet_last_out  = mux_last_s;
        src_ready_out      = grant_r & {NUM_SRC{mac_rnet_ready_in}};
        arb_grant_out      = grant_r;
        arb_frame_cnt_out  = frame_cnt_r;
        if (state_r != ST_IDLE) begin
            arb_busy_out = 1'b1;
        end else begin
            arb_busy_out = 1'b0;
        end
    end

    // Grant, round-robin pointer and frame counter
    always_ff @(posedge logic_clk or negedge logic_rst_n) begin
        if (!logic_rst_n) begin
            grant_r     <= {NUM_SRC{1'b0}};
            rr_ptr_r    <= {PTR_W{1'b0}};
            frame_cnt_r <= {CNT_WIDTH{1'b0}};
        end else if ((state_r == ST_IDLE) && any_req_s) begin
            grant_r     <= sel_s;
            rr_ptr_r    <= rr_ptr_r;
            frame_cnt_r <= frame_cnt_r;
        end else if (last_xfer_s) begin
            grant_r     <= {NUM_SRC{1'b0}};
            rr_ptr_r    <= next_ptr_s;
            frame_cnt_r <= frame_cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            grant_r     <= grant_r;
            rr_ptr_r    <= rr_ptr_r;
            frame_cnt_r <= frame_cnt_r;
        end
    end

`ifdef MAC_TX_ARB_GAP_EN
    // Inter-frame gap down-counter, loaded on the last beat of each frame
    always_ff @(posedge logic_clk or negedge logic_rst_n) begin
        if (!logic_rst_n) begin
            gap_cnt_r <= 8'd0;
        end else if (last_xfer_s) begin
            gap_cnt_r <= GAP_LOAD;
        end else if ((state_r == ST_GAP) && (gap_cnt_r != 8'd0)) begin
            gap_cnt_r <= gap_cnt_r - 8'd1;
        end else begin
            gap_cnt_r <= gap_cnt_r;
        end
    end
`endif

endmodule
